// File: rtl/kv_mem_block.sv
// kv_mem_block: key/value cell array with key/one-hot-index lookup,
// single-cycle write/delete, free-slot, occupancy and illegal-cmd flags.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   select_in            0 = key lookup, 1 = index read at idx_in
//   write_in, delete_in  commit into / clear cell idx_in at next edge
//   idx_in               one-hot target cell
//   key_in, value_in     lookup/write key, write value
//   hit, hit_idx         lookup result and one-hot cell of the hit
//   value_out            value of the hit cell, 0 on miss
//   free_idx             lowest invalid cell (one-hot), 0 when full
//   full, empty, count   occupancy
//   illegal_cmd          malformed command, suppresses all updates
module kv_mem_block #(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 64,
  localparam int CW = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   select_in,
  input  logic                   write_in,
  input  logic                   delete_in,
  input  logic [NUM_ENTRIES-1:0] idx_in,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  output logic                   hit,
  output logic [NUM_ENTRIES-1:0] hit_idx,
  output logic [VALUE_WIDTH-1:0] value_out,
  output logic [NUM_ENTRIES-1:0] free_idx,
  output logic                   full,
  output logic                   empty,
  output logic [CW-1:0]          count,
  output logic                   illegal_cmd
);

  localparam logic [NUM_ENTRIES-1:0] ONE_N = NUM_ENTRIES'(1);
  localparam logic [CW-1:0]          ONE_C = CW'(1);
  localparam logic [CW-1:0]          MAX_C = CW'(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [KEY_WIDTH-1:0]   key_q   [NUM_ENTRIES];
  logic [KEY_WIDTH-1:0]   key_d   [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] value_q [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] value_d [NUM_ENTRIES];
  logic [CW-1:0]          count_q, count_d;

  logic                   idx_onehot;
  logic [NUM_ENTRIES-1:0] match;
  logic [NUM_ENTRIES-1:0] key_hit;
  logic [NUM_ENTRIES-1:0] idx_hit;
  logic                   tgt_valid;
  logic                   do_wr;
  logic                   do_del;

  // x & (x-1) clears the lowest set bit; zero result means at most one bit
  assign idx_onehot = (idx_in != '0) &&
                      ((idx_in & (idx_in - ONE_N)) == '0);

  assign illegal_cmd = (write_in & delete_in) |
                       ((write_in | delete_in) & ~idx_onehot);

  assign do_wr  = write_in  & ~illegal_cmd;
  assign do_del = delete_in & ~illegal_cmd;

  assign tgt_valid = |(valid_q & idx_in);

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = valid_q[i] && (key_q[i] == key_in);
    end
  end

  // isolate lowest set bit: x & -x
  assign key_hit = match & (~match + ONE_N);
  assign idx_hit = idx_onehot ? (idx_in & valid_q) : '0;

  assign hit_idx = select_in ? idx_hit : key_hit;
  assign hit     = |hit_idx;

  always_comb begin
    value_out = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (hit_idx[i]) value_out = value_out | value_q[i];
    end
  end

  // lowest clear bit: ~x & (x+1); wraps to 0 when all cells valid
  assign free_idx = ~valid_q & (valid_q + ONE_N);

  assign count = count_q;
  assign full  = (count_q == MAX_C);
  assign empty = (count_q == '0);

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      key_d[i]   = key_q[i];
      value_d[i] = value_q[i];
      if (idx_in[i] && do_wr) begin
        key_d[i]   = key_in;
        value_d[i] = value_in;
        valid_d[i] = 1'b1;
      end else if (idx_in[i] && do_del) begin
        key_d[i]   = '0;
        value_d[i] = '0;
        valid_d[i] = 1'b0;
      end
    end
    unique case (1'b1)
      do_wr && !tgt_valid: count_d = count_q + ONE_C;
      do_del && tgt_valid: count_d = count_q - ONE_C;
      default:             count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        key_q[i]   <= '0;
        value_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        key_q[i]   <= key_d[i];
        value_q[i] <= value_d[i];
      end
    end
  end

endmodule
